// File: rtl/aes_key_expand_buffer.sv
// AES-128 key expansion engine: one round per clock, all 11 round keys kept in a slot buffer.
// Optional KEYEXP_ZEROIZE_EN: a flush also clears every slot to zero.
module aes_key_expand_buffer #(
    parameter int unsigned OUT_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         flush,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_rnd,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e       state_q, state_d;
    logic [3:0]   rnd_cnt_q, rnd_cnt_d;
    logic [127:0] slot_q [11];

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_data;
    logic         clear_all;
    logic [3:0]   prev_idx;
    logic [127:0] prev_key, next_key, rd_data;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Single-round key function F(prev_key, rnd_cnt).
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

    always_comb begin
        prev_idx = (rnd_cnt_q == 4'd0) ? 4'd0 : rnd_cnt_q - 4'd1;
        prev_key = slot_q[prev_idx];
        {w0, w1, w2, w3} = prev_key;
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]) ^ rcon(rnd_cnt_q), sbox(rot[23:16]), sbox(rot[15:8]),
               sbox(rot[7:0])};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d   = state_q;
        rnd_cnt_d = rnd_cnt_q;
        wr_en     = 1'b0;
        wr_idx    = 4'd0;
        wr_data   = '0;
        clear_all = 1'b0;
        if (flush) begin
            state_d   = StIdle;
            rnd_cnt_d = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
            clear_all = 1'b1;
`endif
        end else begin
            unique case (state_q)
                StIdle, StReady: begin
                    if (key_valid) begin
                        wr_en     = 1'b1;
                        wr_data   = key_in;
                        rnd_cnt_d = 4'd1;
                        state_d   = StExpand;
                    end
                end
                StExpand: begin
                    wr_en   = 1'b1;
                    wr_idx  = rnd_cnt_q;
                    wr_data = next_key;
                    // Counter saturates at 10 once the last slot is written.
                    if (rnd_cnt_q == 4'd10) state_d = StReady;
                    else rnd_cnt_d = rnd_cnt_q + 4'd1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rnd_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            rnd_cnt_q <= rnd_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) slot_q[i] <= '0;
        end else if (clear_all) begin
            for (int i = 0; i < 11; i++) slot_q[i] <= '0;
        end else if (wr_en) begin
            slot_q[wr_idx] <= wr_data;
        end
    end

    assign key_ready  = (state_q != StExpand);
    assign busy       = (state_q == StExpand);
    assign keys_valid = (state_q == StReady);

    assign rd_data = (rd_rnd < 4'd11) ? slot_q[rd_rnd] : '0;

    generate
        if (OUT_REG != 0) begin : g_rd_reg
            logic [127:0] rd_key_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rd_key_q <= '0;
                else rd_key_q <= rd_data;
            end
            assign rd_key = rd_key_q;
        end else begin : g_rd_comb
            assign rd_key = rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_expand_buffer.sv
// Directed bench for aes_key_expand_buffer with FIPS-197 key schedule vectors (OUT_REG=1).
module tb_aes_key_expand_buffer;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KX     = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         flush;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_rnd;
    logic [127:0] rd_key;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    aes_key_expand_buffer #(.OUT_REG(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .flush     (flush),
        .busy      (busy),
        .keys_valid(keys_valid),
        .rd_rnd    (rd_rnd),
        .rd_key    (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until keys_valid rises, bounded at 20.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (keys_valid) break;
        end
    endtask

    task automatic read_slot(input logic [3:0] idx);
        rd_rnd = idx;
        tick();
    endtask

    initial begin
        rst_n = 1'b1; key_in = '0; key_valid = 1'b0; flush = 1'b0; rd_rnd = 4'd0;
        #2 rst_n = 1'b0;
        #2;
        check_val("rst_key_ready", 128'(key_ready), 128'd1);
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_keys_valid", 128'(keys_valid), 128'd0);
        check_val("rst_rd_key", rd_key, '0);
        #9 rst_n = 1'b1;
        tick();

        // Accept K1, then hold key_valid with another key throughout expansion.
        key_in = K1; key_valid = 1'b1;
        tick();
        key_in = KX;
        check_val("exp_busy", 128'(busy), 128'd1);
        check_val("exp_key_ready", 128'(key_ready), 128'd0);
        check_val("exp_keys_valid", 128'(keys_valid), 128'd0);
        wait_ready(lat);
        key_valid = 1'b0;
        check_val("k1_latency", 128'(lat), 128'd10);
        check_val("ready_busy", 128'(busy), 128'd0);
        check_val("ready_key_ready", 128'(key_ready), 128'd1);

        read_slot(4'd0);
        check_val("k1_r0", rd_key, K1);
        read_slot(4'd1);
        check_val("k1_r1", rd_key, K1_R1);
        rd_rnd = 4'd10;
        check_val("rd_latency_hold", rd_key, K1_R1);
        tick();
        check_val("k1_r10", rd_key, K1_R10);
        read_slot(4'd11);
        check_val("rd_11_zero", rd_key, '0);
        read_slot(4'd15);
        check_val("rd_15_zero", rd_key, '0);

        // Re-key from READY.
        key_in = K2; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check_val("rekey_kv_drop", 128'(keys_valid), 128'd0);
        check_val("rekey_busy", 128'(busy), 128'd1);
        wait_ready(lat);
        check_val("k2_latency", 128'(lat), 128'd10);
        read_slot(4'd0);
        check_val("k2_r0", rd_key, K2);
        read_slot(4'd10);
        check_val("k2_r10", rd_key, K2_R10);

        // Flush when rnd_cnt reaches 5.
        key_in = K1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush_busy", 128'(busy), 128'd0);
        check_val("flush_keys_valid", 128'(keys_valid), 128'd0);
        check_val("flush_key_ready", 128'(key_ready), 128'd1);
        read_slot(4'd0);
`ifdef KEYEXP_ZEROIZE_EN
        check_val("flush_r0", rd_key, '0);
`else
        check_val("flush_r0", rd_key, K1);
`endif

        // flush beats a simultaneous key_valid.
        key_in = K2; key_valid = 1'b1; flush = 1'b1;
        tick();
        key_valid = 1'b0; flush = 1'b0;
        check_val("flush_wins_busy", 128'(busy), 128'd0);
        check_val("flush_wins_ready", 128'(key_ready), 128'd1);

        // Asynchronous reset in the middle of an expansion.
        key_in = K2; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 128'(busy), 128'd0);
        check_val("mid_rst_key_ready", 128'(key_ready), 128'd1);
        check_val("mid_rst_keys_valid", 128'(keys_valid), 128'd0);
        check_val("mid_rst_rd_key", rd_key, '0);
        #2 rst_n = 1'b1;
        read_slot(4'd0);
        check_val("post_rst_r0", rd_key, '0);
        read_slot(4'd3);
        check_val("post_rst_r3", rd_key, '0);
        check_val("post_rst_busy", 128'(busy), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
